// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the inverse cipher datapath.
// The inverse S-box is a flat constant table indexed from the MSB so byte 0x00 sits at the top.
package aes_pkg;

  localparam int         AES_BLK_W = 128;
  localparam logic [3:0] NR_128    = 4'd10;
  localparam logic [3:0] NR_192    = 4'd12;
  localparam logic [3:0] NR_256    = 4'd14;

  typedef logic [AES_BLK_W-1:0] state_t;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_HOLD  = 2'd3
  } fsm_e;

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Zero marks an unsupported encoding; callers treat it as illegal.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (key_len_e'(kl))
      KEY_128: return NR_128;
      KEY_192: return NR_192;
      KEY_256: return NR_256;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return INV_SBOX_TBL[2047 - 8*idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a small constant k (used with 9, 11, 13, 14).
  function automatic logic [7:0] gmul_k(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (k[3] ? b8 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^
           (k[1] ? b2 : 8'h00) ^ (k[0] ? b  : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last_round is set. Byte i of the block is row i%4, column i/4.
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t rk_i,
  input  logic   last_round_i,
  output state_t state_o
);

  state_t shifted;
  state_t subbed;
  state_t keyed;
  state_t mixed;

  always_comb begin
    shifted = '0;
    subbed  = '0;
    keyed   = '0;
    mixed   = '0;
    // Row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = state_i[127 - 8*(4*((c - r) & 3) + r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      subbed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]);
    end
    keyed = subbed ^ rk_i;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = keyed[127 - 8*(4*c)     -: 8];
      a1 = keyed[127 - 8*(4*c + 1) -: 8];
      a2 = keyed[127 - 8*(4*c + 2) -: 8];
      a3 = keyed[127 - 8*(4*c + 3) -: 8];
      mixed[127 - 8*(4*c)     -: 8] = gmul_k(a0, 4'd14) ^ gmul_k(a1, 4'd11) ^
                                      gmul_k(a2, 4'd13) ^ gmul_k(a3, 4'd9);
      mixed[127 - 8*(4*c + 1) -: 8] = gmul_k(a0, 4'd9)  ^ gmul_k(a1, 4'd14) ^
                                      gmul_k(a2, 4'd11) ^ gmul_k(a3, 4'd13);
      mixed[127 - 8*(4*c + 2) -: 8] = gmul_k(a0, 4'd13) ^ gmul_k(a1, 4'd9)  ^
                                      gmul_k(a2, 4'd14) ^ gmul_k(a3, 4'd11);
      mixed[127 - 8*(4*c + 3) -: 8] = gmul_k(a0, 4'd11) ^ gmul_k(a1, 4'd13) ^
                                      gmul_k(a2, 4'd9)  ^ gmul_k(a3, 4'd14);
    end
  end

  assign state_o = last_round_i ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock, one block in flight.
// Mode is chosen per block from key_len; rk_flat is the forward schedule, walked backwards.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int MAX_NR    = 14,
  parameter int KEY_LEN_W = 2
)
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [AES_BLK_W-1:0]              in_data,
  input  logic [KEY_LEN_W-1:0]              key_len,
  input  logic [AES_BLK_W*(MAX_NR+1)-1:0]   rk_flat,
  input  logic                              clear,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [AES_BLK_W-1:0]              out_data,
  output logic                              err
);

  localparam logic [3:0] MAX_NR_L = 4'(MAX_NR);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // out_valid/out_data stay stable until out_ready; clear pre-empts any transfer that cycle.

  fsm_e       state_q, state_d;
  logic [3:0] r_q, r_d;
  state_t     data_q, data_d;
  logic       out_valid_q, out_valid_d;
  state_t     out_data_q, out_data_d;
  logic       err_q, err_d;

  state_t     rk_arr [MAX_NR+1];
  logic [3:0] nr_in;
  logic       mode_bad;
  logic [3:0] rk_idx;
  state_t     rk_sel;
  state_t     round_out;

  for (genvar i = 0; i <= MAX_NR; i++) begin : g_rk
    assign rk_arr[i] = rk_flat[AES_BLK_W*i +: AES_BLK_W];
  end

  assign nr_in    = nr_of(key_len);
  assign mode_bad = (nr_in == 4'd0) || (nr_in > MAX_NR_L);
  assign in_ready = (state_q == ST_IDLE) && !rst;

  // In IDLE the whitening key rk[nr] is selected; afterwards the counter walks down to 0.
  assign rk_idx = (state_q == ST_IDLE) ? (mode_bad ? 4'd0 : nr_in) : r_q;
  assign rk_sel = rk_arr[rk_idx];

  aes_inv_round_comb u_round (
    .state_i      (data_q),
    .rk_i         (rk_sel),
    .last_round_i (state_q == ST_FINAL),
    .state_o      (round_out)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = 1'b0;
    if (clear) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (mode_bad) begin
              err_d = 1'b1;
            end else begin
              data_d  = in_data ^ rk_sel;
              r_d     = nr_in - 4'd1;
              state_d = (nr_in > 4'd1) ? ST_ROUND : ST_FINAL;
            end
          end
        end
        ST_ROUND: begin
          data_d = round_out;
          r_d    = r_q - 4'd1;
          if (r_q == 4'd1) begin
            state_d = ST_FINAL;
          end
        end
        ST_FINAL: begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using the FIPS-197 appendix C vectors.
// Round-key schedules are expanded here from an S-box derived arithmetically.
`timescale 1ns/1ps
module tb_aes_inv_cipher_iter;

  localparam int MAX_NR = 14;
  localparam int RKW    = 128*(MAX_NR+1);
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [1:0]     key_len;
  logic [RKW-1:0] rk_flat;
  logic           clear;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]     sbox [256];
  logic [RKW-1:0] sched [3];
  logic [RKW-1:0] rk_prev;

  aes_inv_cipher_iter #(.MAX_NR(MAX_NR), .KEY_LEN_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_len   (key_len),
    .rk_flat   (rk_flat),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // The schedule must not move while a block is in flight.
  always @(negedge clk) begin
    assert (rst || in_ready || rk_flat === rk_prev)
      else $error("FAIL rk_flat_stable: schedule changed while a block was in flight");
    rk_prev = rk_flat;
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key bytes are 00,01,02,... as in the FIPS-197 appendix C examples.
  task automatic expand(input int nk, output logic [RKW-1:0] flat);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    flat = '0;
    for (int k = 0; k <= nr; k++) flat[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // driver tasks
  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic send(input logic [1:0] kl, input logic [127:0] data, output int acc);
    wait_ready();
    key_len  = kl;
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc      = cyc;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic watch_quiet(input string name, input int ncyc);
    logic seen_valid, seen_err;
    seen_valid = 1'b0; seen_err = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen_valid = 1'b1;
      if (err !== 1'b0) seen_err = 1'b1;
    end
    n_tests++;
    if (seen_valid || seen_err) begin
      n_fail++;
      $display("FAIL %s quiet: out_valid seen=%b err seen=%b, required 0/0", name, seen_valid, seen_err);
    end
  endtask

  // tests
  task automatic test_reset();
    #12;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", out_data); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset release in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [1:0] kl, input logic [127:0] ct, input int nr);
    int lat, acc;
    rk_flat   = sched[kl];
    out_ready = 1'b1;
    send(kl, ct, acc);
    wait_out(lat);
    n_tests++;
    if (lat != nr) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, nr); end
    n_tests++;
    if (out_data !== PT) begin n_fail++; $display("FAIL %s data: got %h want %h", name, out_data, PT); end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, lat;
    rk_flat   = sched[0];
    out_ready = 1'b1;
    send(2'd0, CT128, a0);
    wait_out(lat);
    n_tests++;
    if (out_data !== PT) begin n_fail++; $display("FAIL b2b first data: got %h want %h", out_data, PT); end
    send(2'd0, CT128, a1);
    n_tests++;
    if (a1 - a0 != 12) begin n_fail++; $display("FAIL b2b period: got %0d want 12", a1 - a0); end
    wait_out(lat);
    n_tests++;
    if (lat != 10 || out_data !== PT) begin
      n_fail++;
      $display("FAIL b2b second: latency %0d data %h want 10 %h", lat, out_data, PT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int acc, lat;
    rk_flat   = sched[0];
    out_ready = 1'b0;
    send(2'd0, CT128, acc);
    wait_out(lat);
    n_tests++;
    if (lat != 10) begin n_fail++; $display("FAIL bp latency: got %0d want 10", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== PT || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp hold[%0d]: out_valid=%b in_ready=%b data=%h want 1/0 %h",
                 i, out_valid, in_ready, out_data, PT);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_tests++;
    if (out_data !== PT) begin n_fail++; $display("FAIL bp retain: got %h want %h", out_data, PT); end
    test_vector("bp_second", 2'd0, CT128, 10);
  endtask

  task automatic test_abort();
    int acc;
    rk_flat   = sched[0];
    out_ready = 1'b1;
    send(2'd0, CT128, acc);
    repeat (3) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_tests++;
    if (out_data !== PT) begin n_fail++; $display("FAIL abort out_data kept: got %h want %h", out_data, PT); end
    watch_quiet("abort", 16);
    clear    = 1'b1;
    key_len  = 2'd0;
    in_data  = CT128;
    in_valid = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear priority: in_ready=%b want 1", in_ready); end
    watch_quiet("clear_priority", 14);
    test_vector("abort_after", 2'd0, CT128, 10);
  endtask

  task automatic test_reset_mid_op();
    int acc;
    rk_flat   = sched[2];
    out_ready = 1'b1;
    send(2'd2, CT256, acc);
    repeat (6) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid ctrl: in_ready=%b out_valid=%b err=%b want 0/0/0", in_ready, out_valid, err);
    end
    n_tests++;
    if (out_data !== 128'h0) begin n_fail++; $display("FAIL rst_mid out_data: got %h want 0", out_data); end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    test_vector("rst_after", 2'd2, CT256, 14);
  endtask

  task automatic test_illegal();
    int acc;
    rk_flat   = sched[1];
    out_ready = 1'b1;
    send(2'd3, CT192, acc);
    n_tests++;
    if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal pulse: err=%b out_valid=%b in_ready=%b want 1/0/1", err, out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal end: err=%b in_ready=%b want 0/1", err, in_ready);
    end
    watch_quiet("illegal", 16);
    test_vector("c2_after_illegal", 2'd1, CT192, 12);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    key_len   = 2'd0;
    clear     = 1'b0;
    out_ready = 1'b1;
    rk_flat   = '0;
    build_sbox();
    expand(4, sched[0]);
    expand(6, sched[1]);
    expand(8, sched[2]);
    test_reset();
    test_vector("c1_aes128", 2'd0, CT128, 10);
    test_vector("c2_aes192", 2'd1, CT192, 12);
    test_vector("c3_aes256", 2'd2, CT256, 14);
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid_op();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
